// File: rtl/mcp_rx_arbiter.sv
// Round-robin receive front end: unloads uart_rx links into one tagged packet FIFO with a valid/ready head.
// Optional build macro DROP_BAD_PARITY_EN: parity-error packets are counted but not queued.
module mcp_rx_arbiter #(
  parameter int WIDTH      = 64,
  parameter int NUM_LINKS  = 4,
  parameter int FIFO_DEPTH = 512,
  parameter int LINK_W     = ($clog2(NUM_LINKS) > 0) ? $clog2(NUM_LINKS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_LINKS-1:0]           rx_empty,
  input  logic [NUM_LINKS*(WIDTH-1)-1:0] rx_data,
  input  logic [NUM_LINKS-1:0]           parity_error,
  output logic [NUM_LINKS-1:0]           uld_rx_data,
  output logic                           pkt_valid,
  input  logic                           pkt_ready,
  output logic [WIDTH-2:0]               pkt_data,
  output logic [LINK_W-1:0]              pkt_link,
  output logic                           pkt_parity_err,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic [31:0]                    rx_count,
  output logic [15:0]                    parity_count
);

  localparam int PAY_W   = WIDTH - 1;
  localparam int ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = ADDR_W + 1;
  localparam int ENTRY_W = 1 + LINK_W + PAY_W;

  typedef enum logic [1:0] {S_IDLE, S_UNLOAD, S_CAPTURE, S_SETTLE} state_t;

  state_t              state_q, state_d;
  logic [LINK_W-1:0]   rr_q, sel_q, pick, pick_hi, pick_lo;
  logic                found_hi, found_lo;
  logic                start, capture, push, pop, fifo_full;
  logic [PAY_W-1:0]    cap_data;
  logic                cap_par, cap_par_stored;
  logic [ENTRY_W-1:0]  wr_entry, head;
  logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr, rd_ptr_d;
  logic [LVL_W-1:0]    level;

  // Round-robin pick: lowest waiting link at or above rr_q, else lowest waiting link overall.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int k = NUM_LINKS - 1; k >= 0; k--) begin
      if (!rx_empty[k]) begin
        found_lo = 1'b1;
        pick_lo  = LINK_W'(k);
        if (LINK_W'(k) >= rr_q) begin
          found_hi = 1'b1;
          pick_hi  = LINK_W'(k);
        end
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    cap_data = '0;
    cap_par  = 1'b0;
    for (int k = 0; k < NUM_LINKS; k++) begin
      if (sel_q == LINK_W'(k)) begin
        cap_data = rx_data[k*PAY_W +: PAY_W];
        cap_par  = parity_error[k];
      end
    end
  end

  assign fifo_full = (level >= LVL_W'(FIFO_DEPTH));
  assign capture   = (state_q == S_CAPTURE);

`ifdef DROP_BAD_PARITY_EN
  assign push           = capture & ~cap_par;
  assign cap_par_stored = 1'b0;
`else
  assign push           = capture;
  assign cap_par_stored = cap_par;
`endif

  assign wr_entry = {cap_par_stored, sel_q, cap_data};

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found_lo && !fifo_full) begin
          start   = 1'b1;
          state_d = S_UNLOAD;
        end
      end
      S_UNLOAD:  state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_SETTLE;
      S_SETTLE:  state_d = S_IDLE;   // rx_empty ignored here while the link flag rises
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_q         <= '0;
      sel_q        <= '0;
      uld_rx_data  <= '0;
      rx_count     <= '0;
      parity_count <= '0;
    end else begin
      state_q     <= state_d;
      uld_rx_data <= '0;
      if (start) begin
        sel_q       <= pick;
        uld_rx_data <= NUM_LINKS'(1) << pick;
      end
      if (capture) begin
        rr_q <= (sel_q == LINK_W'(NUM_LINKS - 1)) ? '0 : sel_q + LINK_W'(1);
        if (cap_par && parity_count != 16'hFFFF) parity_count <= parity_count + 16'd1;
      end
      if (push) rx_count <= rx_count + 32'd1;
    end
  end

  // NOTE: the storage array has no reset; level/pointers define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign pop      = pkt_valid & pkt_ready;
  assign rd_ptr_d = rd_ptr + ADDR_W'(pop);

  // Head register reads the entry that will be at the front after this edge; an entry written
  // on this same edge is not counted yet, so it surfaces one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pkt_valid <= 1'b0;
      head      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      rd_ptr    <= rd_ptr_d;
      level     <= level + LVL_W'(push) - LVL_W'(pop);
      pkt_valid <= (level - LVL_W'(pop)) != '0;
      head      <= mem[rd_ptr_d];
    end
  end

  assign pkt_data       = head[PAY_W-1:0];
  assign pkt_link       = head[PAY_W +: LINK_W];
  assign pkt_parity_err = head[ENTRY_W-1];
  assign fifo_level     = level;

endmodule

// File: tb/tb_mcp_rx_arbiter.sv
// Self-checking bench for mcp_rx_arbiter: uart_rx link models feed the DUT, a scoreboard checks
// every popped packet, and per-scenario tasks check timing, fairness, backpressure and reset.
module tb_mcp_rx_arbiter;

  localparam int NL    = 4;
  localparam int PW    = 63;
  localparam int DEPTH = 4;
`ifdef DROP_BAD_PARITY_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  typedef struct {logic [PW-1:0] d; logic p;} pkt_t;
  typedef struct {logic [PW-1:0] d; logic [1:0] link; logic p;} exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NL-1:0]     rx_empty = '1;
  logic [NL*PW-1:0]  rx_data = '0;
  logic [NL-1:0]     parity_error = '0;
  logic [NL-1:0]     uld_rx_data;
  logic              pkt_valid;
  logic              pkt_ready = 1'b0;
  logic [PW-1:0]     pkt_data;
  logic [1:0]        pkt_link;
  logic              pkt_parity_err;
  logic [2:0]        fifo_level;
  logic [31:0]       rx_count;
  logic [15:0]       parity_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  pkt_t        lq [NL][$];
  pkt_t        cur [NL];
  int          hold [NL] = '{default: 0};
  exp_t        sb [$];
  int          served [$];
  logic [31:0] exp_rx  = '0;
  logic [15:0] exp_par = '0;

  mcp_rx_arbiter #(.WIDTH(64), .NUM_LINKS(NL), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .rx_data(rx_data),
    .parity_error(parity_error), .uld_rx_data(uld_rx_data), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready), .pkt_data(pkt_data), .pkt_link(pkt_link),
    .pkt_parity_err(pkt_parity_err), .fifo_level(fifo_level), .rx_count(rx_count),
    .parity_count(parity_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation still running at 500us, required completion");
    $fatal(1, "watchdog expired");
  end

  // uart_rx link models plus output monitor, all on the falling edge.
  // A link clears empty when unloaded and offers its next packet two cycles later.
  initial begin : link_model
    logic [NL-1:0] prev_uld;
    exp_t e;
    prev_uld = '0;
    forever begin
      @(negedge clk);
      if (uld_rx_data != '0) begin
        n_checks++;
        if (!$onehot(uld_rx_data) || prev_uld != '0) begin
          n_fail++;
          $display("FAIL uld_onehot: uld=%b prev=%b, required one-hot for one cycle", uld_rx_data, prev_uld);
        end
      end
      prev_uld = uld_rx_data;
      for (int k = 0; k < NL; k++) begin
        if (uld_rx_data[k]) begin
          n_checks++;
          if (rx_empty[k]) begin
            n_fail++;
            $display("FAIL uld_empty_link: link %0d unloaded with nothing waiting, required a waiting packet", k);
          end else begin
            served.push_back(k);
            if (cur[k].p && exp_par != 16'hFFFF) exp_par = exp_par + 16'd1;
            if (!(DROP && cur[k].p)) begin
              e.d = cur[k].d; e.link = 2'(k); e.p = cur[k].p;
              sb.push_back(e);
              exp_rx = exp_rx + 32'd1;
            end
          end
          rx_empty[k] = 1'b1;
          hold[k] = 2;
        end else if (hold[k] > 0) begin
          hold[k]--;
        end
        if (hold[k] == 0 && rx_empty[k] && lq[k].size() > 0) begin
          cur[k] = lq[k].pop_front();
          rx_empty[k] = 1'b0;
          rx_data[k*PW +: PW] = cur[k].d;
          parity_error[k] = cur[k].p;
        end
      end
      if (pkt_valid && pkt_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL pop_unexpected: got data=%h link=%0d, required no packet", pkt_data, pkt_link);
        end else begin
          e = sb.pop_front();
          if (pkt_data !== e.d || pkt_link !== e.link || pkt_parity_err !== e.p) begin
            n_fail++;
            $display("FAIL pop_data: got data=%h link=%0d par=%b, required data=%h link=%0d par=%b",
                     pkt_data, pkt_link, pkt_parity_err, e.d, e.link, e.p);
          end
        end
      end
    end
  end

  task automatic offer(input int k, input logic [PW-1:0] d, input logic p);
    pkt_t t;
    t.d = d;
    t.p = p;
    lq[k].push_back(t);
  endtask

  function automatic bit links_idle();
    for (int k = 0; k < NL; k++)
      if (lq[k].size() != 0 || hold[k] != 0 || !rx_empty[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (n < 300 && !(links_idle() && sb.size() == 0 && fifo_level == 3'd0)) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (n >= 300) begin
      n_fail++;
      $display("FAIL %s_drain: pending=%0d level=%0d after 300 cycles, required empty", tag, sb.size(), fifo_level);
    end
  endtask

  task automatic check_counters(input string tag);
    n_checks++;
    if (rx_count !== exp_rx || parity_count !== exp_par) begin
      n_fail++;
      $display("FAIL %s_counters: rx=%0d par=%0d, required rx=%0d par=%0d", tag, rx_count, parity_count, exp_rx, exp_par);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (uld_rx_data !== '0 || pkt_valid !== 1'b0 || pkt_data !== '0 || pkt_link !== '0 ||
        pkt_parity_err !== 1'b0 || fifo_level !== '0 || rx_count !== '0 || parity_count !== '0) begin
      n_fail++;
      $display("FAIL reset_state: uld=%b valid=%b data=%h link=%0d perr=%b level=%0d rx=%0d par=%0d, required all zero",
               uld_rx_data, pkt_valid, pkt_data, pkt_link, pkt_parity_err, fifo_level, rx_count, parity_count);
    end
    reset = 1'b0;
  endtask

  // Cycle 1 is the cycle in which rx_empty falls; uld follows in cycle 2, pkt_valid in cycle 5.
  task automatic test_single_link();
    int cyc, valid_cyc, uld_cyc, uld_hits;
    logic [NL-1:0] uld_seen;
    pkt_ready = 1'b1;
    @(posedge clk); #1;
    offer(0, 63'h0000_0000_0000_0402, 1'b0);
    cyc = 1; valid_cyc = 0; uld_cyc = 0; uld_hits = 0; uld_seen = '0;
    while (cyc < 12 && valid_cyc == 0) begin
      @(posedge clk); #1;
      cyc++;
      if (uld_rx_data != '0) begin
        uld_hits++;
        uld_cyc  = cyc;
        uld_seen = uld_rx_data;
      end
      if (pkt_valid) valid_cyc = cyc;
    end
    n_checks++;
    if (valid_cyc != 5) begin
      n_fail++;
      $display("FAIL single_latency: pkt_valid in cycle %0d, required cycle 5", valid_cyc);
    end
    n_checks++;
    if (uld_hits != 1 || uld_cyc != 2 || uld_seen !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_uld: %0d pulses, cycle %0d, value %b, required 1 pulse in cycle 2 of 0001", uld_hits, uld_cyc, uld_seen);
    end
    n_checks++;
    if (pkt_link !== 2'd0 || pkt_data !== 63'h402 || pkt_parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_head: link=%0d data=%h perr=%b, required link=0 data=402 perr=0", pkt_link, pkt_data, pkt_parity_err);
    end
    wait_drain("single");
    n_checks++;
    if (rx_count !== 32'd1) begin
      n_fail++;
      $display("FAIL single_rx_count: got %0d, required 1", rx_count);
    end
  endtask

  // The previous packet came from link 0, so the round-robin pointer now starts at link 1.
  task automatic test_fairness();
    pkt_ready = 1'b1;
    served.delete();
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NL; k++) offer(k, 63'((r << 12) | (k << 2) | 32'hF0000), 1'b0);
    repeat (32) @(posedge clk);
    #1;
    n_checks++;
    if (served.size() != 8) begin
      n_fail++;
      $display("FAIL fair_throughput: %0d packets unloaded in 32 cycles, required 8", served.size());
    end
    for (int i = 0; i < 8 && i < served.size(); i++) begin
      n_checks++;
      if (served[i] != (1 + i) % NL) begin
        n_fail++;
        $display("FAIL fair_order[%0d]: link %0d, required link %0d", i, served[i], (1 + i) % NL);
      end
    end
    wait_drain("fair");
    check_counters("fair");
  endtask

  task automatic test_parity();
    int valid_cycles;
    logic perr_seen;
    pkt_ready = 1'b1;
    valid_cycles = 0;
    perr_seen = 1'b0;
    @(posedge clk); #1;
    offer(1, 63'h0000_0000_0000_1235, 1'b1);
    repeat (16) begin
      @(posedge clk); #1;
      if (pkt_valid) begin
        valid_cycles++;
        perr_seen = pkt_parity_err;
      end
    end
    n_checks++;
    if (parity_count !== 16'd1) begin
      n_fail++;
      $display("FAIL parity_count: got %0d, required 1", parity_count);
    end
    n_checks++;
    if (DROP ? (valid_cycles != 0) : (valid_cycles == 0 || perr_seen !== 1'b1)) begin
      n_fail++;
      $display("FAIL parity_head: valid for %0d cycles with perr=%b, required %s", valid_cycles, perr_seen,
               DROP ? "no pkt_valid" : "pkt_valid with perr=1");
    end
    wait_drain("parity");
    check_counters("parity");
  endtask

  // Pointer is at link 2 here: 2,3,0,1 fill the FIFO, then the second packets on 0 and 1 follow.
  task automatic test_backpressure();
    int uld_pulses;
    int exp_order [6] = '{2, 3, 0, 1, 0, 1};
    pkt_ready = 1'b0;
    served.delete();
    @(posedge clk); #1;
    offer(0, 63'h0A0, 1'b0); offer(1, 63'h0A1, 1'b0); offer(2, 63'h0A2, 1'b0);
    offer(3, 63'h0A3, 1'b0); offer(0, 63'h0B0, 1'b0); offer(1, 63'h0B1, 1'b0);
    repeat (30) @(posedge clk);
    uld_pulses = 0;
    repeat (16) begin
      @(posedge clk); #1;
      if (uld_rx_data != '0) uld_pulses++;
    end
    n_checks++;
    if (fifo_level !== 3'd4 || pkt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_level: level=%0d valid=%b, required level=4 valid=1", fifo_level, pkt_valid);
    end
    n_checks++;
    if (uld_pulses != 0 || served.size() != 4) begin
      n_fail++;
      $display("FAIL bp_stall: %0d unload pulses while full, %0d served, required 0 pulses and 4 served", uld_pulses, served.size());
    end
    pkt_ready = 1'b1;
    wait_drain("bp");
    n_checks++;
    if (served.size() != 6) begin
      n_fail++;
      $display("FAIL bp_total: %0d served, required 6", served.size());
    end
    for (int i = 0; i < 6 && i < served.size(); i++) begin
      n_checks++;
      if (served[i] != exp_order[i]) begin
        n_fail++;
        $display("FAIL bp_order[%0d]: link %0d, required link %0d", i, served[i], exp_order[i]);
      end
    end
    check_counters("bp");
  endtask

  task automatic test_back_to_back();
    logic [2:0] max_level;
    pkt_ready = 1'b1;
    served.delete();
    max_level = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) offer(2, 63'(32'h5500 + i), 1'b0);
    repeat (40) begin
      @(posedge clk); #1;
      if (fifo_level > max_level) max_level = fifo_level;
    end
    n_checks++;
    if (max_level > 3'd1 || served.size() != 6) begin
      n_fail++;
      $display("FAIL b2b_level: max level %0d with %0d served, required max 1 and 6 served", max_level, served.size());
    end
    wait_drain("b2b");
    check_counters("b2b");
  endtask

  // Three packets wait in the FIFO when reset hits the fourth transfer in UNLOAD.
  task automatic test_reset_midop();
    int n;
    pkt_ready = 1'b0;
    served.delete();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) offer(2, 63'(32'h7700 + i), 1'b0);
    n = 0;
    while (n < 100 && !(uld_rx_data != '0 && fifo_level == 3'd3)) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n >= 100) begin
      n_fail++;
      $display("FAIL midop_setup: level=%0d after 100 cycles, required fourth unload with level 3", fifo_level);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (uld_rx_data !== '0 || pkt_valid !== 1'b0 || fifo_level !== '0 || rx_count !== '0 || parity_count !== '0) begin
      n_fail++;
      $display("FAIL midop_reset: uld=%b valid=%b level=%0d rx=%0d par=%0d, required all zero",
               uld_rx_data, pkt_valid, fifo_level, rx_count, parity_count);
    end
    sb.delete();
    served.delete();
    for (int k = 0; k < NL; k++) begin
      lq[k].delete();
      hold[k] = 0;
    end
    rx_empty = '1;
    exp_rx = '0;
    exp_par = '0;
    reset = 1'b0;
    pkt_ready = 1'b1;
    @(posedge clk); #1;
    offer(3, 63'h0C3, 1'b0);
    offer(0, 63'h0C0, 1'b0);
    wait_drain("midop");
    n_checks++;
    if (served.size() != 2 || served[0] != 0 || served[1] != 3) begin
      n_fail++;
      $display("FAIL midop_first_link: %0d served, first link %0d, required 2 served starting at link 0 then 3",
               served.size(), served.size() > 0 ? served[0] : -1);
    end
    check_counters("midop");
  endtask

  initial begin
    test_reset();
    test_single_link();
    test_fairness();
    test_parity();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
